// File: rtl/enable_pulse_debouncer.sv
// Push-button conditioner: synchronizer, debounce FSM and optional auto-repeat timer.
// Emits a one-cycle enable pulse per accepted press (and per repeat event) plus the debounced level.
module enable_pulse_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_i,
  output logic enable_o,
  output logic pressed_o
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DB_N   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DLY_N  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER_N  = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          rpt;
  logic                   rpt_phase;
  logic                   sync_q;
  logic [CW-1:0]          cnt_nxt;
  logic [CW-1:0]          rpt_nxt;
  logic [CW-1:0]          rpt_target;

  assign sync_q     = sync_r[SYNC_STAGES-1];
  assign cnt_nxt    = cnt + ONE;
  assign rpt_nxt    = rpt + ONE;
  // First repeat waits the long delay; later ones use the shorter period.
  assign rpt_target = rpt_phase ? PER_N : DLY_N;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_r    <= '0;
      state     <= IDLE;
      cnt       <= '0;
      rpt       <= '0;
      rpt_phase <= 1'b0;
      enable_o  <= 1'b0;
      pressed_o <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], button_i};
      enable_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q) begin
            state <= PRESS_WAIT;
            cnt   <= ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_nxt == DB_N) begin
            state     <= PRESSED;
            cnt       <= '0;
            rpt       <= '0;
            rpt_phase <= 1'b0;
            enable_o  <= 1'b1;
            pressed_o <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        PRESSED: begin
          if (!sync_q) begin
            state <= RELEASE_WAIT;
            cnt   <= ONE;
          end else if (REPEAT_EN != 0) begin
            // Guard on enable_o keeps pulses non-adjacent even with 1-cycle delay/period.
            if (rpt_nxt == rpt_target) begin
              rpt       <= '0;
              rpt_phase <= 1'b1;
              enable_o  <= !enable_o;
            end else begin
              rpt <= rpt_nxt;
            end
          end
        end
        RELEASE_WAIT: begin
          if (sync_q) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt_nxt == DB_N) begin
            state     <= IDLE;
            cnt       <= '0;
            pressed_o <= 1'b0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enable_pulse_debouncer.sv
// Directed bench for enable_pulse_debouncer: latency, bounce rejection, release,
// mid-press reset, auto-repeat timing and a 4-bit counter wrap fed by enable_o.
module tb_enable_pulse_debouncer;
  logic clk = 1'b0;
  logic rst, btn, en, prs;
  logic rst_r, btn_r, en_r, prs_r;
  logic [3:0] cnt4;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enable_pulse_debouncer dut (
    .clock_i(clk), .reset_i(rst), .button_i(btn), .enable_o(en), .pressed_o(prs)
  );

  enable_pulse_debouncer #(.REPEAT_EN(1), .REPEAT_DELAY(64), .REPEAT_PERIOD(16)) dut_rpt (
    .clock_i(clk), .reset_i(rst_r), .button_i(btn_r), .enable_o(en_r), .pressed_o(prs_r)
  );

  // Stand-in for the downstream 4-bit counter.
  always @(posedge clk)
    if (rst) cnt4 <= 4'h0;
    else if (en) cnt4 <= cnt4 + 4'd1;

  task automatic test_reset;
    rst = 1'b1; rst_r = 1'b1; btn = 1'b1; btn_r = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en got %b want 0", en); end
    total++; if (prs !== 1'b0) begin bad++; $display("FAIL reset_prs got %b want 0", prs); end
    total++; if (en_r !== 1'b0) begin bad++; $display("FAIL reset_en_rpt got %b want 0", en_r); end
    total++; if (prs_r !== 1'b0) begin bad++; $display("FAIL reset_prs_rpt got %b want 0", prs_r); end
    rst = 1'b0; rst_r = 1'b0; btn = 1'b0; btn_r = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (prs !== 1'b0 || en !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got en=%b prs=%b want 0 0", en, prs);
    end
  endtask

  // Button held 100 cycles: single pulse after edge 18, pressed from then on.
  task automatic test_press_latency;
    btn = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clk);
      total++; if (en !== (e == 18)) begin bad++; $display("FAIL press_en edge %0d got %b want %b", e, en, e == 18); end
      total++; if (prs !== (e >= 18)) begin bad++; $display("FAIL press_prs edge %0d got %b want %b", e, prs, e >= 18); end
    end
  endtask

  task automatic test_release;
    btn = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      total++; if (en !== 1'b0) begin bad++; $display("FAIL release_en edge %0d got %b want 0", e, en); end
      total++; if (prs !== (e < 18)) begin bad++; $display("FAIL release_prs edge %0d got %b want %b", e, prs, e < 18); end
    end
  endtask

  task automatic test_bounce;
    logic [42:0] pat;
    pat = {30'h0, 5'b11111, 3'b000, 5'b11111};
    for (int i = 0; i < 43; i++) begin
      btn = pat[i];
      @(negedge clk);
      total++; if (en !== 1'b0 || prs !== 1'b0) begin
        bad++; $display("FAIL bounce cycle %0d got en=%b prs=%b want 0 0", i, en, prs);
      end
    end
  endtask

  task automatic test_release_bounce;
    btn = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (prs !== 1'b1) begin bad++; $display("FAIL rb_setup_prs got %b want 1", prs); end
    for (int i = 0; i < 40; i++) begin
      btn = (i >= 10);
      @(negedge clk);
      total++; if (en !== 1'b0 || prs !== 1'b1) begin
        bad++; $display("FAIL release_bounce cycle %0d got en=%b prs=%b want 0 1", i, en, prs);
      end
    end
    btn = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (prs !== 1'b0) begin bad++; $display("FAIL rb_final_prs got %b want 0", prs); end
  endtask

  // Reset while PRESSED with button held: treated as a brand-new press.
  task automatic test_reset_mid;
    btn = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (prs !== 1'b1) begin bad++; $display("FAIL rm_setup_prs got %b want 1", prs); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (en !== 1'b0 || prs !== 1'b0) begin
      bad++; $display("FAIL reset_mid_out got en=%b prs=%b want 0 0", en, prs);
    end
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      total++; if (en !== (e == 18)) begin bad++; $display("FAIL rm_en edge %0d got %b want %b", e, en, e == 18); end
      total++; if (prs !== (e >= 18)) begin bad++; $display("FAIL rm_prs edge %0d got %b want %b", e, prs, e >= 18); end
    end
    btn = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  // Repeat pulses at acceptance, +64, then every 16 cycles through +192.
  task automatic test_repeat;
    int o;
    int nrep;
    logic exp_en;
    nrep = 0;
    btn_r = 1'b1;
    for (int e = 1; e <= 217; e++) begin
      @(negedge clk);
      o = e - 18;
      exp_en = (o == 0) || (o >= 64 && ((o - 64) % 16) == 0);
      if (o >= 1 && en_r === 1'b1) nrep++;
      total++; if (en_r !== exp_en) begin bad++; $display("FAIL repeat_en edge %0d got %b want %b", e, en_r, exp_en); end
      total++; if (prs_r !== (e >= 18)) begin bad++; $display("FAIL repeat_prs edge %0d got %b want %b", e, prs_r, e >= 18); end
    end
    total++; if (nrep != 9) begin bad++; $display("FAIL repeat_count got %0d want 9", nrep); end
    btn_r = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (prs_r !== 1'b0) begin bad++; $display("FAIL repeat_release_prs got %b want 0", prs_r); end
  endtask

  task automatic test_counter_wrap;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 17; p++) begin
      btn = 1'b1;
      repeat (25) @(negedge clk);
      btn = 1'b0;
      repeat (25) @(negedge clk);
    end
    total++; if (cnt4 !== 4'h1) begin bad++; $display("FAIL counter_wrap got %h want 1", cnt4); end
    total++; if (prs !== 1'b0) begin bad++; $display("FAIL counter_wrap_prs got %b want 0", prs); end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_release();
    test_bounce();
    test_release_bounce();
    test_reset_mid();
    test_repeat();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
